// File: rtl/interrupt_dispatcher.sv
// interrupt_dispatcher: accepts an irq at an instruction boundary, pushes the return PC, and jumps to the ISR
module interrupt_dispatcher #(
  parameter int DATA_WIDTH     = 8,
  parameter int I_ADDR_WIDTH   = 10,
  parameter int VEC_TIM0_OVF   = 5,
  parameter int VEC_TIM0_COMPA = 6,
  parameter int VEC_TIM0_COMPB = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    irq,
  input  logic [I_ADDR_WIDTH-1:0] vector,
  input  logic                    insn_boundary,
  input  logic [I_ADDR_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0]   sp,
  output logic                    stall,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    sp_we,
  output logic [DATA_WIDTH-1:0]   sp_new,
  output logic                    pc_load,
  output logic [I_ADDR_WIDTH-1:0] pc_new,
  output logic                    sreg_i_clr,
  output logic [DATA_WIDTH-1:0]   tifr_clr
);
  typedef enum logic [2:0] {IDLE, PUSH_L, PUSH_H, JUMP, SETTLE} state_t;
  state_t                  state_q, state_d;
  logic [I_ADDR_WIDTH-1:0] vec_q, vec_d, pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   sp_q, sp_d, mask;
  logic                    push_l, push_h, jump;
  // State and captured request; reset abandons any partially pushed frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      pc_q    <= '0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
    end
  end
  // Fixed entry sequence; SETTLE ignores irq, which may still show the pre-JUMP request
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    case (state_q)
      IDLE: if (irq && insn_boundary) begin
        state_d = PUSH_L;
        vec_d   = vector;
        pc_d    = pc;
        sp_d    = sp;
      end
      PUSH_L:  state_d = PUSH_H;
      PUSH_H:  state_d = JUMP;
      JUMP:    state_d = SETTLE;
      default: state_d = IDLE;
    endcase
  end
  // Ack mask: one TIFR flag per known timer vector, none for anything else
  always_comb begin
    mask = (vec_q == I_ADDR_WIDTH'(VEC_TIM0_OVF))   ? DATA_WIDTH'(1) :
           (vec_q == I_ADDR_WIDTH'(VEC_TIM0_COMPA)) ? DATA_WIDTH'(2) :
           (vec_q == I_ADDR_WIDTH'(VEC_TIM0_COMPB)) ? DATA_WIDTH'(4) : '0;
  end
  // Moore outputs from the state register and captured copies only
  always_comb begin
    push_l     = state_q == PUSH_L;
    push_h     = state_q == PUSH_H;
    jump       = state_q == JUMP;
    stall      = push_l || push_h || jump;
    mem_we     = push_l || push_h;
    mem_addr   = push_l ? sp_q : push_h ? sp_q - DATA_WIDTH'(1) : '0;
    mem_wdata  = push_l ? DATA_WIDTH'(pc_q[7:0]) :
                 push_h ? DATA_WIDTH'(pc_q[I_ADDR_WIDTH-1:8]) : '0;
    sp_we      = jump;
    sp_new     = jump ? sp_q - DATA_WIDTH'(2) : '0;
    pc_load    = jump;
    pc_new     = jump ? vec_q : '0;
    sreg_i_clr = jump;
    tifr_clr   = jump ? mask : '0;
  end
endmodule

// File: tb/tb_interrupt_dispatcher.sv
// tb_interrupt_dispatcher: scenario tasks checked against a frame-level model of interrupt entry
module tb_interrupt_dispatcher;
  logic       clk = 0, reset = 1, irq = 0, insn_boundary = 0;
  logic [9:0] vector = 0, pc = 0;
  logic [7:0] sp = 0;
  logic       stall, mem_we, sp_we, pc_load, sreg_i_clr;
  logic [7:0] mem_addr, mem_wdata, sp_new, tifr_clr;
  logic [9:0] pc_new;
  logic [46:0] obs;
  int total = 0, bad = 0, n_acc = 0, exp_w = 0, nw = 0, nl = 0;

  interrupt_dispatcher dut (
    .clk(clk), .reset(reset), .irq(irq), .vector(vector), .insn_boundary(insn_boundary),
    .pc(pc), .sp(sp), .stall(stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .sp_we(sp_we), .sp_new(sp_new), .pc_load(pc_load),
    .pc_new(pc_new), .sreg_i_clr(sreg_i_clr), .tifr_clr(tifr_clr)
  );

  always #5 clk = ~clk;
  assign obs = {stall, mem_we, mem_addr, mem_wdata, sp_we, sp_new, pc_load, pc_new, sreg_i_clr, tifr_clr};

  always @(negedge clk) if (!reset) begin
    if (mem_we) nw++;
    if (pc_load) nl++;
  end

  // Expected outputs for cycle ph after acceptance (0 = first push, 2 = jump, else quiet)
  function automatic logic [46:0] model(int ph, int vec, int pcv, int spv);
    logic [7:0] m;
    m = vec == 5 ? 8'h01 : vec == 6 ? 8'h02 : vec == 7 ? 8'h04 : 8'h00;
    case (ph)
      0: return {1'b1, 1'b1, 8'(spv), 8'(pcv % 256), 1'b0, 8'h0, 1'b0, 10'h0, 1'b0, 8'h0};
      1: return {1'b1, 1'b1, 8'((spv + 255) % 256), 8'(pcv / 256), 1'b0, 8'h0, 1'b0, 10'h0, 1'b0, 8'h0};
      2: return {1'b1, 1'b0, 8'h0, 8'h0, 1'b1, 8'((spv + 254) % 256), 1'b1, 10'(vec), 1'b1, m};
      default: return '0;
    endcase
  endfunction

  task automatic test_reset();
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_outputs obs=%h exp=0", obs); end
    @(negedge clk) reset = 0;
    irq = 1; insn_boundary = 1; vector = 10'd5; pc = 10'h155; sp = 8'h70;
    @(posedge clk); #1;
    irq = 0; insn_boundary = 0;
    @(posedge clk); #1;
    total++;
    if (obs !== model(1, 5, 'h155, 'h70)) begin bad++; $display("FAIL reset_pre_push_h obs=%h exp=%h", obs, model(1, 5, 'h155, 'h70)); end
    #2 reset = 1;
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_async obs=%h exp=0", obs); end
    exp_w += 1;
    @(negedge clk) reset = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== '0) begin bad++; $display("FAIL reset_after k=%0d obs=%h exp=0", k, obs); end
    end
  endtask

  task automatic test_entry(input int vec, input int pcv, input int spv, input string nm);
    @(negedge clk);
    irq = 1; insn_boundary = 1; vector = 10'(vec); pc = 10'(pcv); sp = 8'(spv);
    @(posedge clk); #1;
    irq = 0; insn_boundary = 1; vector = 10'($urandom); pc = 10'($urandom); sp = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs !== model(k, vec, pcv, spv)) begin bad++; $display("FAIL %s k=%0d obs=%h exp=%h", nm, k, obs, model(k, vec, pcv, spv)); end
      @(posedge clk); #1;
    end
    n_acc++; exp_w += 2;
  endtask

  task automatic test_boundary_gating();
    @(negedge clk);
    irq = 1; insn_boundary = 0; vector = 10'd6; pc = 10'h0F0; sp = 8'h20;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== '0) begin bad++; $display("FAIL gating_idle k=%0d obs=%h exp=0", k, obs); end
    end
    @(negedge clk) insn_boundary = 1;
    @(posedge clk); #1;
    irq = 0; insn_boundary = 0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs !== model(k, 6, 'h0F0, 'h20)) begin bad++; $display("FAIL gating_entry k=%0d obs=%h exp=%h", k, obs, model(k, 6, 'h0F0, 'h20)); end
      @(posedge clk); #1;
    end
    n_acc++; exp_w += 2;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    irq = 1; insn_boundary = 1; vector = 10'd5; pc = 10'h123; sp = 8'h80;
    @(posedge clk); #1;
    vector = 10'd6; pc = 10'h3C4; sp = 8'h40;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (obs !== model(k, 5, 'h123, 'h80)) begin bad++; $display("FAIL b2b_first k=%0d obs=%h exp=%h", k, obs, model(k, 5, 'h123, 'h80)); end
      @(posedge clk); #1;
    end
    irq = 0; insn_boundary = 0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs !== model(k, 6, 'h3C4, 'h40)) begin bad++; $display("FAIL b2b_second k=%0d obs=%h exp=%h", k, obs, model(k, 6, 'h3C4, 'h40)); end
      @(posedge clk); #1;
    end
    n_acc += 2; exp_w += 4;
  endtask

  task automatic test_random();
    int vec, pcv, spv, r;
    for (int i = 0; i < 20; i++) begin
      r = int'($urandom % 4);
      vec = r < 3 ? 5 + r : int'($urandom % 1024);
      pcv = int'($urandom % 1024);
      spv = int'($urandom % 256);
      for (int g = 0; g < int'($urandom % 4); g++) begin
        @(negedge clk);
        irq = 1'($urandom); insn_boundary = 0;
        @(posedge clk); #1;
        total++;
        if (obs !== '0) begin bad++; $display("FAIL rand_gap i=%0d obs=%h exp=0", i, obs); end
      end
      @(negedge clk);
      irq = 1; insn_boundary = 1; vector = 10'(vec); pc = 10'(pcv); sp = 8'(spv);
      @(posedge clk); #1;
      irq = 1'($urandom); insn_boundary = 0; vector = 10'($urandom); pc = 10'($urandom); sp = 8'($urandom);
      for (int k = 0; k < 4; k++) begin
        total++;
        if (obs !== model(k, vec, pcv, spv)) begin bad++; $display("FAIL rand_entry i=%0d k=%0d obs=%h exp=%h", i, k, obs, model(k, vec, pcv, spv)); end
        @(posedge clk); #1;
      end
      n_acc++; exp_w += 2;
    end
    irq = 0;
  endtask

  task automatic test_totals();
    @(negedge clk); @(negedge clk);
    total++;
    if (nl !== n_acc) begin bad++; $display("FAIL pc_load_count obs=%0d exp=%0d", nl, n_acc); end
    total++;
    if (nw !== exp_w) begin bad++; $display("FAIL mem_write_count obs=%0d exp=%0d", nw, exp_w); end
  endtask

  initial begin
    test_reset();
    test_entry(5, 'h2A7, 'h5F, "ovf_entry");
    test_entry(7, 'h001, 'h00, "compb_wrap");
    test_boundary_gating();
    test_back_to_back();
    test_entry(3, 'h0AB, 'h33, "unknown_vec");
    test_random();
    test_totals();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
